// File: rtl/display_pkg.sv
// Shared definitions for the display-start controller family:
// FSM encoding, bus widths and default frame-buffer placement.
package display_pkg;

  localparam int DISP_ADDR_W = 30;
  localparam int FRAME_CNT_W = 16;

  localparam logic [DISP_ADDR_W-1:0] DEF_BASE_ADDR  = 30'h10426240;
  localparam logic [DISP_ADDR_W-1:0] DEF_BUF_STRIDE = 30'h00025800;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_WAIT  = 2'd1,
    S_APPLY = 2'd2,
    S_CLR   = 2'd3
  } state_t;

endpackage

// File: rtl/disp_addr_calc.sv
// Buffer index to frame-buffer word address: BASE_ADDR + idx * BUF_STRIDE,
// wrapped to the display address width.
module disp_addr_calc
  import display_pkg::*;
#(
  parameter logic [DISP_ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [DISP_ADDR_W-1:0] BUF_STRIDE = DEF_BUF_STRIDE,
  parameter int                     IDX_W      = 3
) (
  input  logic [IDX_W-1:0]       idx,
  output logic [DISP_ADDR_W-1:0] addr
);

  logic [DISP_ADDR_W-1:0] idx_ext;

  always_comb begin
    idx_ext = {{(DISP_ADDR_W-IDX_W){1'b0}}, idx};
    addr    = BASE_ADDR + idx_ext * BUF_STRIDE;
  end

endmodule

// File: rtl/display_page_flipper.sv
// Display-start controller: selects the frame buffer shown by the display IP,
// applying host flip requests or round-robin advance once per vblank.
module display_page_flipper
  import display_pkg::*;
#(
  parameter int                     NUM_BUF    = 2,
  parameter logic [DISP_ADDR_W-1:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter logic [DISP_ADDR_W-1:0] BUF_STRIDE = DEF_BUF_STRIDE,
  parameter int                     IDX_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   VBLANK,
  output logic                   CLRVBLNK,
  output logic [DISP_ADDR_W-1:0] DISPADDR,
  output logic                   DISPON,
  input  logic                   disp_en,
  input  logic                   auto_flip,
  input  logic                   flip_req,
  input  logic [IDX_W-1:0]       flip_idx,
  output logic                   flip_ack,
  output logic                   flip_err,
  output logic [IDX_W-1:0]       cur_buf,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [IDX_W:0]   NUM_BUF_C = (IDX_W+1)'(NUM_BUF);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BUF - 1);

  state_t                 state, state_nx;
  logic                   pending;
  logic [IDX_W-1:0]       pend_idx;
  logic                   req_ok;
  logic [IDX_W-1:0]       next_buf;
  logic [DISP_ADDR_W-1:0] next_addr;

  logic                   clr_d, on_d, ack_d;
  logic [DISP_ADDR_W-1:0] addr_d;
  logic [IDX_W-1:0]       buf_d;
  logic [FRAME_CNT_W-1:0] cnt_d;

  assign req_ok = ({1'b0, flip_idx} < NUM_BUF_C);

  always_comb begin
    next_buf = cur_buf;
    if (pending) begin
      next_buf = pend_idx;
    end else if (auto_flip && (NUM_BUF > 1)) begin
      next_buf = (cur_buf == LAST_IDX) ? '0 : cur_buf + IDX_W'(1);
    end
  end

  disp_addr_calc #(
    .BASE_ADDR (BASE_ADDR),
    .BUF_STRIDE(BUF_STRIDE),
    .IDX_W     (IDX_W)
  ) u_addr (
    .idx (next_buf),
    .addr(next_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_INIT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT:  state_nx = S_WAIT;
      S_WAIT:  if (VBLANK) state_nx = S_APPLY;
      S_APPLY: state_nx = S_CLR;
      S_CLR:   if (!VBLANK) state_nx = S_WAIT;
      default: state_nx = S_INIT;
    endcase
  end

  always_comb begin
    clr_d  = CLRVBLNK;
    on_d   = DISPON;
    addr_d = DISPADDR;
    buf_d  = cur_buf;
    cnt_d  = frame_cnt;
    ack_d  = 1'b0;
    unique case (state)
      S_INIT:  clr_d = 1'b0;
      S_APPLY: begin
        buf_d  = next_buf;
        addr_d = next_addr;
        on_d   = disp_en;
        cnt_d  = frame_cnt + FRAME_CNT_W'(1);
        clr_d  = 1'b1;
        ack_d  = pending;
      end
      S_CLR:   if (!VBLANK) clr_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      CLRVBLNK  <= 1'b1;
      DISPADDR  <= '0;
      DISPON    <= 1'b0;
      flip_ack  <= 1'b0;
      cur_buf   <= '0;
      frame_cnt <= '0;
    end else begin
      CLRVBLNK  <= clr_d;
      DISPADDR  <= addr_d;
      DISPON    <= on_d;
      flip_ack  <= ack_d;
      cur_buf   <= buf_d;
      frame_cnt <= cnt_d;
    end
  end

  // A request landing on the apply edge must survive the consume-clear,
  // so capture is given priority over clearing the pending flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= 1'b0;
      pend_idx <= '0;
      flip_err <= 1'b0;
    end else begin
      flip_err <= flip_req && !req_ok;
      if (flip_req && req_ok) begin
        pending  <= 1'b1;
        pend_idx <= flip_idx;
      end else if (state == S_APPLY) begin
        pending  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_page_flipper.sv
// Bench for display_page_flipper: a 3-buffer and a 1-buffer instance share
// stimulus and are checked every cycle against a frame-level model.
module tb_display_page_flipper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblank = 1'b0;
  logic        disp_en = 1'b0;
  logic        auto_flip = 1'b0;
  logic        flip_req = 1'b0;
  logic [2:0]  flip_idx = '0;

  logic        o_clr [2];
  logic [29:0] o_addr[2];
  logic        o_on  [2];
  logic        o_ack [2];
  logic        o_err [2];
  logic [2:0]  o_buf [2];
  logic [15:0] o_cnt [2];

  always #5 clk = ~clk;

  display_page_flipper #(.NUM_BUF(3), .IDX_W(3)) dut_a (
    .clk(clk), .rst(rst), .VBLANK(vblank), .CLRVBLNK(o_clr[0]),
    .DISPADDR(o_addr[0]), .DISPON(o_on[0]), .disp_en(disp_en),
    .auto_flip(auto_flip), .flip_req(flip_req), .flip_idx(flip_idx),
    .flip_ack(o_ack[0]), .flip_err(o_err[0]), .cur_buf(o_buf[0]),
    .frame_cnt(o_cnt[0])
  );

  display_page_flipper #(.NUM_BUF(1), .IDX_W(3)) dut_b (
    .clk(clk), .rst(rst), .VBLANK(vblank), .CLRVBLNK(o_clr[1]),
    .DISPADDR(o_addr[1]), .DISPON(o_on[1]), .disp_en(disp_en),
    .auto_flip(auto_flip), .flip_req(flip_req), .flip_idx(flip_idx),
    .flip_ack(o_ack[1]), .flip_err(o_err[1]), .cur_buf(o_buf[1]),
    .frame_cnt(o_cnt[1])
  );

  // Frame-level model: one apply per vblank, addresses by plain arithmetic.
  int          nb[2] = '{3, 1};
  logic        m_clr [2];
  logic [29:0] m_addr[2];
  logic        m_on  [2];
  logic        m_ack [2];
  logic        m_err [2];
  logic [2:0]  m_buf [2];
  logic [15:0] m_cnt [2];
  bit          m_started[2], m_armed[2], m_apply[2], m_clearing[2], m_pend[2];
  logic [2:0]  m_pidx[2];

  always @(posedge clk or negedge rst) begin
    logic [2:0]  b, pi;
    logic [29:0] ad;
    logic [15:0] cn;
    logic [63:0] t;
    bit          cl, on, ac, er, st, ar, ap, cg, pe;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_clr[i] <= 1'b1; m_addr[i] <= '0; m_on[i] <= 1'b0; m_ack[i] <= 1'b0;
        m_err[i] <= 1'b0; m_buf[i] <= '0; m_cnt[i] <= '0;
        m_started[i] <= 1'b0; m_armed[i] <= 1'b0; m_apply[i] <= 1'b0;
        m_clearing[i] <= 1'b0; m_pend[i] <= 1'b0; m_pidx[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        b = m_buf[i]; pi = m_pidx[i]; ad = m_addr[i]; cn = m_cnt[i];
        cl = m_clr[i]; on = m_on[i]; st = m_started[i]; ar = m_armed[i];
        ap = m_apply[i]; cg = m_clearing[i]; pe = m_pend[i];
        ac = 1'b0; er = 1'b0;
        if (!st) begin
          st = 1'b1; cl = 1'b0; ar = 1'b1;
        end else if (ap) begin
          if (pe) begin
            b = pi; pe = 1'b0; ac = 1'b1;
          end else if (auto_flip && nb[i] > 1) begin
            b = 3'((int'(b) + 1) % nb[i]);
          end
          t  = 64'h10426240 + 64'(b) * 64'h25800;
          ad = t[29:0];
          on = disp_en; cn = cn + 16'd1; cl = 1'b1; ap = 1'b0; cg = 1'b1;
        end else if (cg) begin
          if (!vblank) begin cl = 1'b0; cg = 1'b0; ar = 1'b1; end
        end else if (ar && vblank) begin
          ar = 1'b0; ap = 1'b1;
        end
        if (flip_req) begin
          if (int'(flip_idx) < nb[i]) begin pe = 1'b1; pi = flip_idx; end
          else er = 1'b1;
        end
        m_buf[i] <= b; m_pidx[i] <= pi; m_addr[i] <= ad; m_cnt[i] <= cn;
        m_clr[i] <= cl; m_on[i] <= on; m_ack[i] <= ac; m_err[i] <= er;
        m_started[i] <= st; m_armed[i] <= ar; m_apply[i] <= ap;
        m_clearing[i] <= cg; m_pend[i] <= pe;
      end
    end
  end

  typedef struct {
    string nm;
    int    dut;
    int    sel;
    logic [31:0] v;
  } lit_t;
  lit_t litq[$];

  int checks = 0;
  int errors = 0;
  bit go = 1'b0;

  function automatic logic [31:0] pick(input int d, input int sel);
    case (sel)
      0: return 32'(o_clr[d]);
      1: return 32'(o_on[d]);
      2: return 32'(o_addr[d]);
      3: return 32'(o_buf[d]);
      4: return 32'(o_cnt[d]);
      5: return 32'(o_ack[d]);
      default: return 32'(o_err[d]);
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    lit_t l;
    if (go) begin
      for (int i = 0; i < 2; i++) begin
        chk("CLRVBLNK",  i, 32'(o_clr[i]),  32'(m_clr[i]));
        chk("DISPADDR",  i, 32'(o_addr[i]), 32'(m_addr[i]));
        chk("DISPON",    i, 32'(o_on[i]),   32'(m_on[i]));
        chk("flip_ack",  i, 32'(o_ack[i]),  32'(m_ack[i]));
        chk("flip_err",  i, 32'(o_err[i]),  32'(m_err[i]));
        chk("cur_buf",   i, 32'(o_buf[i]),  32'(m_buf[i]));
        chk("frame_cnt", i, 32'(o_cnt[i]),  32'(m_cnt[i]));
      end
      while (litq.size() > 0) begin
        l = litq.pop_front();
        chk(l.nm, l.dut, pick(l.dut, l.sel), l.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string nm, input int d, input int sel, input logic [31:0] v);
    litq.push_back('{nm, d, sel, v});
  endtask

  task automatic req(input logic [2:0] idx, input bit exp_err);
    flip_req = 1'b1; flip_idx = idx;
    tick();
    lit("err_pulse", 0, 6, 32'(exp_err));
    flip_req = 1'b0;
    tick();
    lit("err_clear", 0, 6, 0);
  endtask

  task automatic frame(input logic [2:0] eb, input bit ea, input bit cr,
                       input logic [2:0] ci);
    vblank = 1'b1;
    tick();
    if (cr) begin flip_req = 1'b1; flip_idx = ci; end
    tick();
    flip_req = 1'b0;
    lit("apply_buf", 0, 3, 32'(eb));
    lit("apply_ack", 0, 5, 32'(ea));
    lit("clr_rise", 0, 0, 1);
    lit("b_buf_zero", 1, 3, 0);
    tick();
    lit("ack_single", 0, 5, 0);
    lit("clr_hold", 0, 0, 1);
    vblank = 1'b0;
    tick();
    lit("clr_fall", 0, 0, 0);
    tick();
  endtask

  initial begin
    #1 rst = 1'b0;
    go = 1'b1;
    #1;
    lit("rst_clr", 0, 0, 1);
    lit("rst_addr", 0, 2, 0);
    lit("rst_cnt", 0, 4, 0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    disp_en = 1'b1;

    frame(3'd0, 1'b0, 1'b0, 3'd0);
    lit("f1_addr", 0, 2, 32'h10426240);
    lit("f1_on", 0, 1, 1);
    lit("f1_cnt", 0, 4, 1);

    req(3'd1, 1'b0);
    frame(3'd1, 1'b1, 1'b0, 3'd0);
    lit("flip1_addr", 0, 2, 32'h1044BA40);

    req(3'd0, 1'b0);
    frame(3'd0, 1'b1, 1'b0, 3'd0);

    auto_flip = 1'b1;
    frame(3'd1, 1'b0, 1'b0, 3'd0);
    frame(3'd2, 1'b0, 1'b0, 3'd0);
    lit("auto2_addr", 0, 2, 32'h10471240);
    frame(3'd0, 1'b0, 1'b0, 3'd0);
    frame(3'd1, 1'b0, 1'b0, 3'd0);
    lit("auto_cnt", 0, 4, 7);
    auto_flip = 1'b0;

    req(3'd3, 1'b1);
    frame(3'd1, 1'b0, 1'b0, 3'd0);

    flip_req = 1'b1; flip_idx = 3'd2; tick();
    flip_idx = 3'd0; tick();
    flip_idx = 3'd5; tick();
    lit("err_idx5", 0, 6, 1);
    flip_req = 1'b0; tick();
    lit("err_once", 0, 6, 0);
    frame(3'd0, 1'b1, 1'b0, 3'd0);

    disp_en = 1'b0;
    frame(3'd0, 1'b0, 1'b1, 3'd2);
    lit("dispon_off", 0, 1, 0);
    disp_en = 1'b1;
    frame(3'd2, 1'b1, 1'b0, 3'd0);

    vblank = 1'b1;
    tick();
    flip_req = 1'b1; flip_idx = 3'd1;
    tick();
    flip_req = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    lit("mid_rst_clr", 0, 0, 1);
    lit("mid_rst_on", 0, 1, 0);
    lit("mid_rst_addr", 0, 2, 0);
    lit("mid_rst_buf", 0, 3, 0);
    vblank = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();
    frame(3'd0, 1'b0, 1'b0, 3'd0);
    lit("post_rst_addr", 0, 2, 32'h10426240);
    lit("post_rst_cnt", 0, 4, 1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
